i2c_wb_arbiter: RTL and testbench

Sequences single-register Wishbone accesses into the I2C EFB Wishbone port and shares that port between two requesters, for example the IMU poller and a configuration loader. Each requester posts one read or write at a time. The block grants requesters round-robin, drives stb/cyc/we/adr/dat to the EFB, waits for ack, and returns read data with a one-cycle done pulse. It sits between the I2C client state machines and the `I2C_EFB_WB` instance.

---
 rtl/i2c_wb_arbiter_pkg.sv | 12 +
 rtl/i2c_wb_arbiter_rr_arb2.sv | 22 ++
 rtl/i2c_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_i2c_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_wb_arbiter_pkg.sv
// Shared constants for the I2C EFB Wishbone arbiter: FSM state codes and
// boolean helpers used across the arbiter files.
package i2c_wb_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic FALSE = 1'b0;
  localparam logic TRUE  = 1'b1;

endpackage

// File: rtl/i2c_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational choice from the request vector
// and the last-grant pointer held by the parent.
module i2c_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    unique case (req)
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/i2c_wb_arbiter.sv
// Shares the I2C EFB Wishbone port between two single-access requesters.
// Optional ack timeout is built when I2C_WB_TIMEOUT_EN is defined.
module i2c_wb_arbiter
  import i2c_wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic              req0_we,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [1:0]        done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i
);

  logic [1:0] state;
  logic       last_grant;
  logic       grant;
  logic       arb_valid;
  logic       arb_grant;
  logic       timeout_hit;

  i2c_rr_arb2 u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

`ifdef I2C_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  always_ff @(posedge sys_clk) begin
    if (rst || state != ST_ISSUE) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_ISSUE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = FALSE;
  assign err            = FALSE;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // updates from pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      wb_stb_o   <= FALSE;
      wb_we_o    <= FALSE;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      done       <= '0;
      rdata      <= '0;
`ifdef I2C_WB_TIMEOUT_EN
      err_q      <= FALSE;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant      <= arb_grant;
            last_grant <= arb_grant;
            wb_we_o    <= arb_grant ? req1_we    : req0_we;
            wb_adr_o   <= arb_grant ? req1_addr  : req0_addr;
            wb_dat_o   <= arb_grant ? req1_wdata : req0_wdata;
            wb_stb_o   <= TRUE;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (wb_ack_i) begin
            wb_stb_o    <= FALSE;
            done[grant] <= TRUE;
            if (!wb_we_o) rdata <= wb_dat_i;
            state       <= ST_GAP;
          end else if (timeout_hit) begin
            wb_stb_o    <= FALSE;
            done[grant] <= TRUE;
            rdata       <= '0;
`ifdef I2C_WB_TIMEOUT_EN
            err_q       <= TRUE;
`endif
            state       <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Idle cycle with stb low keeps a late EFB ack off the next access.
          done  <= '0;
`ifdef I2C_WB_TIMEOUT_EN
          err_q <= FALSE;
`endif
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wb_cyc_o = wb_stb_o;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Self-checking bench for i2c_wb_arbiter: EFB responder model, scoreboard of
// expected completions, vector table plus reset/contention/timeout sequences.
module tb_i2c_wb_arbiter;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       req0_we, req1_we;
  logic [7:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic [1:0] done;
  logic       err, busy, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [7:0] rdata, wb_adr_o, wb_dat_o, wb_dat_i;

  always #5 sys_clk = ~sys_clk;

  i2c_wb_arbiter #(.TIMEOUT_CYCLES(15), .ADDR_W(8), .DATA_W(8)) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req),
    .req0_we(req0_we), .req1_we(req1_we),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  typedef struct {
    int         idx;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         delay;
    logic [7:0] efb;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0] done;
    logic       err;
    logic [7:0] rdata;
    logic [7:0] adr;
    logic [7:0] dat;
    logic       we;
    int         stb_len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // EFB responder: ack 'ack_delay' cycles after stb rises; 0 means never.
  int         ack_delay = 1;
  logic [7:0] efb_data  = 8'h00;
  int         stb_cnt   = 0;
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(negedge sys_clk);
      wb_ack_i = 1'b0;
      if (!rst && wb_stb_o && ack_delay != 0) begin
        stb_cnt++;
        if (stb_cnt == ack_delay) begin
          wb_ack_i = 1'b1;
          wb_dat_i = efb_data;
        end
      end else begin
        stb_cnt = 0;
      end
    end
  end

  // Monitor: captures each access on the bus and scores every done pulse.
  logic       stb_prev = 1'b0;
  int         stb_len = 0;
  int         gap = 0;
  bit         had_access = 1'b0;
  bit         m_stable = 1'b1;
  bit         m_cyc_ok = 1'b1;
  logic [7:0] m_adr, m_dat;
  logic       m_we;
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        had_access = 1'b0;
        stb_len    = 0;
        gap        = 0;
      end else begin
        if (wb_cyc_o !== wb_stb_o) m_cyc_ok = 1'b0;
        if (wb_stb_o) begin
          if (!stb_prev) begin
            if (had_access) check("stb_gap_ge2", 32'(gap >= 2), 1);
            stb_len  = 0;
            m_stable = 1'b1;
            m_adr    = wb_adr_o;
            m_dat    = wb_dat_o;
            m_we     = wb_we_o;
          end
          if (wb_adr_o !== m_adr || wb_dat_o !== m_dat || wb_we_o !== m_we) m_stable = 1'b0;
          stb_len++;
        end else begin
          if (stb_prev) begin
            gap        = 0;
            had_access = 1'b1;
          end
          gap++;
        end
        if (done != 2'b00) begin
          done_seen++;
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 0);
          end else begin
            e = sb.pop_front();
            check("done",    32'(done),     32'(e.done));
            check("err",     32'(err),      32'(e.err));
            check("rdata",   32'(rdata),    32'(e.rdata));
            check("wb_adr",  32'(m_adr),    32'(e.adr));
            check("wb_dat",  32'(m_dat),    32'(e.dat));
            check("wb_we",   32'(m_we),     32'(e.we));
            check("stb_len", 32'(stb_len),  32'(e.stb_len));
            check("stable",  32'(m_stable), 1);
            check("cyc_stb", 32'(m_cyc_ok), 1);
          end
        end
      end
      stb_prev = wb_stb_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(output logic [1:0] d);
    d = 2'b00;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (done != 2'b00) begin
        d = done;
        return;
      end
    end
    check("done_wait_bound", 1, 0);
  endtask

  task automatic push_exp(input logic [1:0] d, input logic e, input logic [7:0] rd,
                          input logic [7:0] a, input logic [7:0] w, input logic we, input int len);
    exp_t x;
    x.done = d; x.err = e; x.rdata = rd; x.adr = a; x.dat = w; x.we = we; x.stb_len = len;
    sb.push_back(x);
  endtask

  vec_t vecs[6];
  logic [1:0] d;
  int   seen_before;

  initial begin
    vecs[0] = '{0, 1'b1, 8'h4A, 8'hC5, 2, 8'h00, 8'h77};
    vecs[1] = '{1, 1'b0, 8'h4C, 8'h00, 1, 8'h3F, 8'h3F};
    vecs[2] = '{0, 1'b1, 8'h10, 8'hAA, 1, 8'h99, 8'h3F};
    vecs[3] = '{0, 1'b0, 8'h4D, 8'h00, 3, 8'h5A, 8'h5A};
    vecs[4] = '{1, 1'b1, 8'h4E, 8'h01, 4, 8'hEE, 8'h5A};
    vecs[5] = '{1, 1'b0, 8'h4F, 8'h00, 1, 8'h00, 8'h00};

    // Reset held with both requesting.
    rst = 1'b1;
    req = 2'b11;
    req0_we = 1'b1; req0_addr = 8'h20; req0_wdata = 8'h11;
    req1_we = 1'b0; req1_addr = 8'h21; req1_wdata = 8'h22;
    ack_delay = 1;
    efb_data  = 8'h77;
    repeat (3) @(negedge sys_clk);
    check("rst_done",  32'(done),     0);
    check("rst_err",   32'(err),      0);
    check("rst_rdata", 32'(rdata),    0);
    check("rst_busy",  32'(busy),     0);
    check("rst_stb",   32'(wb_stb_o), 0);
    check("rst_cyc",   32'(wb_cyc_o), 0);
    check("rst_we",    32'(wb_we_o),  0);
    check("rst_adr",   32'(wb_adr_o), 0);
    check("rst_dat",   32'(wb_dat_o), 0);

    // Contention: grants alternate 0,1,0,1 starting with requester 0.
    push_exp(2'b01, 1'b0, 8'h00, 8'h20, 8'h11, 1'b1, 1);
    push_exp(2'b10, 1'b0, 8'h77, 8'h21, 8'h22, 1'b0, 1);
    push_exp(2'b01, 1'b0, 8'h77, 8'h20, 8'h11, 1'b1, 1);
    push_exp(2'b10, 1'b0, 8'h77, 8'h21, 8'h22, 1'b0, 1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_done(d);
      req = req & ~d;
      @(negedge sys_clk);
      if (k < 2) req = req | d;
    end
    req = 2'b00;

    // Vector table of single accesses.
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      ack_delay = vecs[i].delay;
      efb_data  = vecs[i].efb;
      if (vecs[i].idx == 0) begin
        req0_we = vecs[i].we; req0_addr = vecs[i].addr; req0_wdata = vecs[i].wdata;
      end else begin
        req1_we = vecs[i].we; req1_addr = vecs[i].addr; req1_wdata = vecs[i].wdata;
      end
      push_exp((vecs[i].idx == 0) ? 2'b01 : 2'b10, 1'b0, vecs[i].exp_rdata,
               vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].delay);
      req[vecs[i].idx] = 1'b1;
      wait_done(d);
      req = 2'b00;
    end

    // Never-acked access.
    @(negedge sys_clk);
    ack_delay = 0;
    req0_we = 1'b0; req0_addr = 8'h4A; req0_wdata = 8'h33;
`ifdef I2C_WB_TIMEOUT_EN
    push_exp(2'b01, 1'b1, 8'h00, 8'h4A, 8'h33, 1'b0, 15);
    req = 2'b01;
    wait_done(d);
    req = 2'b00;
    @(negedge sys_clk);
    check("err_cleared", 32'(err), 0);
    req = 2'b01;
    repeat (5) @(negedge sys_clk);
`else
    req = 2'b01;
    repeat (120) @(negedge sys_clk);
    check("no_timeout_stb", 32'(wb_stb_o), 1);
    check("no_timeout_err", 32'(err),      0);
`endif

    // Reset while stb is high abandons the access without done.
    check("mid_stb_before", 32'(wb_stb_o), 1);
    seen_before = done_seen;
    rst = 1'b1;
    @(negedge sys_clk);
    check("mid_rst_stb",  32'(wb_stb_o), 0);
    check("mid_rst_cyc",  32'(wb_cyc_o), 0);
    check("mid_rst_busy", 32'(busy),     0);
    check("mid_rst_done", 32'(done),     0);
    rst = 1'b0;
    req = 2'b00;
    repeat (8) @(negedge sys_clk);
    check("mid_rst_no_done", 32'(done_seen), 32'(seen_before));
    check("mid_rst_idle",    32'(busy),      0);
    check("sb_drained",      32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
